aes_dec_first_round: RTL and testbench

AES_DEC_FIRST_ROUND -- requirements
Module: aes_dec_first_round

---
 rtl/aes_dec_first_round.sv | 150 +++++++++++++++
 tb/tb_aes_dec_first_round.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/aes_dec_first_round.sv
// First round of AES-128 decryption as a 3-stage valid/ready pipeline:
// AddRoundKey, InvShiftRows, InvSubBytes, with the previous round key derived alongside.
module aes_dec_first_round (
    input  logic         clk,
    input  logic         rst,
    input  logic [3:0]   rnd,
    input  logic [0:127] rk_in,
    input  logic [0:127] data_in,
    input  logic         in_valid,
    output logic         in_ready,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [0:127] data_out,
    output logic [0:127] key_out
);

    // Internally byte 0 (port bit 0) sits in the most significant byte of a [127:0] vector.
    logic         s1Valid, s2Valid, s3Valid;
    logic [127:0] s1Data, s2Data, s3Data;
    logic [127:0] s1Key, s2Key, s3Key;
    logic [7:0]   s1Rcon;
    logic         advance;

    function automatic logic [7:0] gfMul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc;
        logic [7:0] x;
        acc = 8'h00;
        x   = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) acc = acc ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return acc;
    endfunction

    // Multiplicative inverse as a^254 (maps 0 to 0, as the S-box requires).
    function automatic logic [7:0] gfInv(input logic [7:0] a);
        logic [7:0] sq;
        logic [7:0] acc;
        sq  = a;
        acc = 8'h01;
        for (int i = 1; i < 8; i++) begin
            sq  = gfMul(sq, sq);
            acc = gfMul(acc, sq);
        end
        return acc;
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] x;
        x = gfInv(a);
        return x ^ {x[6:0], x[7]} ^ {x[5:0], x[7:6]} ^ {x[4:0], x[7:5]}
                 ^ {x[3:0], x[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [7:0] invSbox(input logic [7:0] a);
        logic [7:0] y;
        y = {a[6:0], a[7]} ^ {a[4:0], a[7:5]} ^ {a[1:0], a[7:2]} ^ 8'h05;
        return gfInv(y);
    endfunction

    function automatic logic [31:0] subWord(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    function automatic logic [31:0] rotWord(input logic [31:0] w);
        return {w[23:0], w[31:24]};
    endfunction

    function automatic logic [7:0] rconFor(input logic [3:0] idx);
        logic [7:0] rc;
        case (idx)
            4'd1:    rc = 8'h01;
            4'd2:    rc = 8'h02;
            4'd3:    rc = 8'h04;
            4'd4:    rc = 8'h08;
            4'd5:    rc = 8'h10;
            4'd6:    rc = 8'h20;
            4'd7:    rc = 8'h40;
            4'd8:    rc = 8'h80;
            4'd9:    rc = 8'h1b;
            4'd10:   rc = 8'h36;
            default: rc = 8'h00;
        endcase
        return rc;
    endfunction

    // Byte r+4c is row r, column c; row r rotates right by r bytes.
    function automatic logic [127:0] invShiftRows(input logic [127:0] st);
        logic [127:0] res;
        res = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                res[127 - 8*(r + 4*c) -: 8] = st[127 - 8*(r + 4*((c - r + 4) % 4)) -: 8];
            end
        end
        return res;
    endfunction

    function automatic logic [127:0] invSubBytes(input logic [127:0] st);
        logic [127:0] res;
        res = '0;
        for (int i = 0; i < 16; i++) begin
            res[127 - 8*i -: 8] = invSbox(st[127 - 8*i -: 8]);
        end
        return res;
    endfunction

    assign advance   = !s3Valid || out_ready;
    assign in_ready  = advance;
    assign out_valid = s3Valid;
    assign data_out  = s3Data;
    assign key_out   = s3Key;

    // Key path: S1 registers the key and Rcon, S2 forms v1..v3 and w0^Rcon,
    // S3 folds in SubWord(RotWord(v3)) so key_out lines up with data_out.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1Valid <= 1'b0;
            s2Valid <= 1'b0;
            s3Valid <= 1'b0;
            // NOTE: data registers are cleared too, so data_out/key_out read 0 after reset.
            s1Data  <= '0;
            s2Data  <= '0;
            s3Data  <= '0;
            s1Key   <= '0;
            s2Key   <= '0;
            s3Key   <= '0;
            s1Rcon  <= '0;
        end else if (advance) begin
            // NOTE: non-blocking assignments let every stage read the previous cycle's value.
            s1Valid <= in_valid;
            s1Data  <= data_in ^ rk_in;
            s1Key   <= rk_in;
            s1Rcon  <= rconFor(rnd);

            s2Valid <= s1Valid;
            s2Data  <= invShiftRows(s1Data);
            s2Key   <= {s1Key[127:96] ^ {s1Rcon, 24'h000000},
                        s1Key[95:64] ^ s1Key[127:96],
                        s1Key[63:32] ^ s1Key[95:64],
                        s1Key[31:0]  ^ s1Key[63:32]};

            s3Valid <= s2Valid;
            s3Data  <= invSubBytes(s2Data);
            s3Key   <= {s2Key[127:96] ^ subWord(rotWord(s2Key[31:0])), s2Key[95:0]};
        end
    end

endmodule

// File: tb/tb_aes_dec_first_round.sv
// Directed self-checking bench for aes_dec_first_round: reset, FIPS-197 vectors,
// streaming, stall, mid-flight reset and out-of-range round index.
module tb_aes_dec_first_round;

    logic         clk = 1'b0;
    logic         rst;
    logic [3:0]   rnd;
    logic [127:0] rkIn;
    logic [127:0] dataIn;
    logic         inValid;
    logic         inReady;
    logic         outValid;
    logic         outReady;
    logic [127:0] dataOut;
    logic [127:0] keyOut;

    int checks = 0;
    int errors = 0;

    localparam logic [127:0] RK10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] RK9  = 128'hac7766f319fadc2128d12941575c006e;
    localparam logic [127:0] RK8  = 128'head27321b58dbad2312bf5607f8d292f;
    localparam logic [127:0] RK2  = 128'hf2c295f27a96b9435935807a7359f67f;
    localparam logic [127:0] RK1  = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] RK0  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] CT   = 128'h3925841d02dc09fbdc118597196a0b32;
    // Round-10 start state of the FIPS-197 App. B trace.
    localparam logic [127:0] PTB  = 128'heb40f21e592e38848ba113e71bc342d2;
    // ShiftRows of S-box(00..0f): decrypts back to 00..0f under a zero key.
    localparam logic [127:0] XIN  = 128'h636b6776f201ab7b30d777c5fe7c6f2b;
    localparam logic [127:0] XOUT = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] ALL52 = {16{8'h52}};
    localparam logic [127:0] KZ10 = {32'h55636363, 96'h0};
    localparam logic [127:0] KZNO = {32'h63636363, 96'h0};
    localparam logic [127:0] RK0X = 128'h2a7e151628aed2a6abf7158809cf4f3c;

    logic [3:0]   vRnd [4];
    logic [127:0] vRk  [4];
    logic [127:0] vDat [4];
    logic [127:0] vExD [4];
    logic [127:0] vExK [4];

    aes_dec_first_round dut (
        .clk       (clk),
        .rst       (rst),
        .rnd       (rnd),
        .rk_in     (rkIn),
        .data_in   (dataIn),
        .in_valid  (inValid),
        .in_ready  (inReady),
        .out_valid (outValid),
        .out_ready (outReady),
        .data_out  (dataOut),
        .key_out   (keyOut)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [3:0] r, input logic [127:0] k, input logic [127:0] d);
        rnd     = r;
        rkIn    = k;
        dataIn  = d;
        inValid = 1'b1;
    endtask

    // One isolated transaction: accept, wait the 3-edge latency, check, confirm no repeat.
    task automatic runOne(input string tag, input logic [3:0] r, input logic [127:0] k,
                          input logic [127:0] d, input logic [127:0] expD, input logic [127:0] expK);
        outReady = 1'b1;
        drive(r, k, d);
        #1;
        check({tag, "_in_ready"}, {127'b0, inReady}, 128'd1);
        tick();
        inValid = 1'b0;
        check({tag, "_lat1"}, {127'b0, outValid}, 128'd0);
        tick();
        check({tag, "_lat2"}, {127'b0, outValid}, 128'd0);
        tick();
        check({tag, "_valid"}, {127'b0, outValid}, 128'd1);
        check({tag, "_data"}, dataOut, expD);
        check({tag, "_key"}, keyOut, expK);
        tick();
        check({tag, "_retired"}, {127'b0, outValid}, 128'd0);
    endtask

    initial begin
        rst = 1'b1; inValid = 1'b0; outReady = 1'b1;
        rnd = 4'd0; rkIn = '0; dataIn = '0;

        vRnd[0] = 4'd10; vRk[0] = RK10; vDat[0] = CT;   vExD[0] = PTB;   vExK[0] = RK9;
        vRnd[1] = 4'd10; vRk[1] = '0;   vDat[1] = XIN;  vExD[1] = XOUT;  vExK[1] = KZ10;
        vRnd[2] = 4'd1;  vRk[2] = RK1;  vDat[2] = RK1;  vExD[2] = ALL52; vExK[2] = RK0;
        vRnd[3] = 4'd9;  vRk[3] = RK9;  vDat[3] = RK9;  vExD[3] = ALL52; vExK[3] = RK8;

        // Reset state
        tick();
        tick();
        check("reset_valid", {127'b0, outValid}, 128'd0);
        check("reset_data", dataOut, '0);
        check("reset_key", keyOut, '0);
        rst = 1'b0;
        #1;
        check("reset_in_ready", {127'b0, inReady}, 128'd1);

        // Accepted in the first cycle after reset; App. B last round
        runOne("appb", 4'd10, RK10, CT, PTB, RK9);
        runOne("key_rnd1", 4'd1, RK1, RK1, ALL52, RK0);
        runOne("key_rnd2", 4'd2, RK2, RK2, ALL52, RK1);
        runOne("shift_pattern", 4'd10, '0, XIN, XOUT, KZ10);

        // Out-of-range round index: Rcon is 00
        runOne("rnd0", 4'd0, RK1, RK1, ALL52, RK0X);
        runOne("rnd12", 4'd12, '0, XIN, XOUT, KZNO);
        runOne("rnd15", 4'd15, RK1, RK1, ALL52, RK0X);

        // Back-to-back streaming
        outReady = 1'b1;
        for (int k = 0; k < 6; k++) begin
            if (k < 4) drive(vRnd[k], vRk[k], vDat[k]);
            else inValid = 1'b0;
            #1;
            check($sformatf("stream_in_ready_%0d", k), {127'b0, inReady}, 128'd1);
            tick();
            if (k >= 2) begin
                check($sformatf("stream_valid_%0d", k), {127'b0, outValid}, 128'd1);
                check($sformatf("stream_data_%0d", k - 2), dataOut, vExD[k - 2]);
                check($sformatf("stream_key_%0d", k - 2), keyOut, vExK[k - 2]);
            end else begin
                check($sformatf("stream_fill_%0d", k), {127'b0, outValid}, 128'd0);
            end
        end
        tick();
        check("stream_drained", {127'b0, outValid}, 128'd0);

        // Stall: fill with out_ready low, hold, then drain
        outReady = 1'b0;
        for (int k = 0; k < 3; k++) begin
            drive(vRnd[k], vRk[k], vDat[k]);
            #1;
            check($sformatf("stall_fill_ready_%0d", k), {127'b0, inReady}, 128'd1);
            tick();
        end
        drive(vRnd[3], vRk[3], vDat[3]);
        #1;
        for (int h = 0; h < 3; h++) begin
            check($sformatf("stall_in_ready_%0d", h), {127'b0, inReady}, 128'd0);
            check($sformatf("stall_valid_%0d", h), {127'b0, outValid}, 128'd1);
            check($sformatf("stall_data_%0d", h), dataOut, vExD[0]);
            check($sformatf("stall_key_%0d", h), keyOut, vExK[0]);
            if (h < 2) tick();
        end
        outReady = 1'b1;
        #1;
        check("stall_release_ready", {127'b0, inReady}, 128'd1);
        tick();
        inValid = 1'b0;
        for (int k = 1; k < 4; k++) begin
            check($sformatf("drain_valid_%0d", k), {127'b0, outValid}, 128'd1);
            check($sformatf("drain_data_%0d", k), dataOut, vExD[k]);
            check($sformatf("drain_key_%0d", k), keyOut, vExK[k]);
            tick();
        end
        check("drain_empty", {127'b0, outValid}, 128'd0);

        // Reset with two entries in flight and a same-cycle input
        outReady = 1'b1;
        drive(vRnd[0], vRk[0], vDat[0]);
        tick();
        drive(vRnd[1], vRk[1], vDat[1]);
        tick();
        drive(vRnd[2], vRk[2], vDat[2]);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        inValid = 1'b0;
        #1;
        check("midrst_valid", {127'b0, outValid}, 128'd0);
        check("midrst_data", dataOut, '0);
        check("midrst_key", keyOut, '0);
        check("midrst_in_ready", {127'b0, inReady}, 128'd1);
        for (int k = 0; k < 4; k++) begin
            tick();
            check($sformatf("midrst_no_stale_%0d", k), {127'b0, outValid}, 128'd0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
